// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: default 640x480@60
// timing, colour types and the bit-replication colour expander.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned H_FP_DEF       = 16;
   localparam int unsigned H_SYNC_DEF     = 96;
   localparam int unsigned H_BP_DEF       = 48;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned V_FP_DEF       = 10;
   localparam int unsigned V_SYNC_DEF     = 2;
   localparam int unsigned V_BP_DEF       = 33;
   localparam int unsigned COLOR_BITS_DEF = 2;

   // Colour as supplied by the game logic at the default depth.
   typedef struct packed {
      logic [COLOR_BITS_DEF-1:0] r;
      logic [COLOR_BITS_DEF-1:0] g;
      logic [COLOR_BITS_DEF-1:0] b;
   } rgb_t;

   // Full-scale colour as presented to the DAC.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;

   // Repeat the low `bits` bits of value MSB-first across 8 bits,
   // so all-ones maps to 8'hFF and zero stays zero.
   function automatic logic [7:0] expand_color(input logic [7:0] value,
                                               input int unsigned bits);
      logic [7:0] res;
      logic [2:0] src;
      res = '0;
      if (bits != 0) begin
         for (int unsigned i = 0; i < 8; i++) begin
            src = 3'(bits - 1 - (i % bits));
            res[3'(7 - i)] = value[src];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bus between the timing generator, the colour source and the video DAC.
// Optional macro VGA_TEST_PATTERN_EN adds the test_mode select.
interface vga_timing_gen_if #(
   parameter int unsigned COLOR_BITS = 2,
   parameter int unsigned XW         = 10,
   parameter int unsigned YW         = 10
);
   logic [3*COLOR_BITS-1:0] rgb_in;
   logic                    pix_ce;
   logic                    req_valid;
   logic [XW-1:0]           x;
   logic [YW-1:0]           y;
   logic                    line_start;
   logic                    frame_start;
   logic                    VGA_CLK;
   logic [7:0]              VGA_R;
   logic [7:0]              VGA_G;
   logic [7:0]              VGA_B;
   logic                    VGA_SYNC_N;
   logic                    VGA_BLANK_N;
   logic                    VGA_HS;
   logic                    VGA_VS;
`ifdef VGA_TEST_PATTERN_EN
   logic                    test_mode;

   modport master (
      input  rgb_in, test_mode,
      output pix_ce, req_valid, x, y, line_start, frame_start,
             VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );
   modport slave (
      output rgb_in, test_mode,
      input  pix_ce, req_valid, x, y, line_start, frame_start,
             VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );
`else
   modport master (
      input  rgb_in,
      output pix_ce, req_valid, x, y, line_start, frame_start,
             VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );
   modport slave (
      output rgb_in,
      input  pix_ce, req_valid, x, y, line_start, frame_start,
             VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
   );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter with
// active-region, sync-level and wrap decodes. Order: active, FP, sync, BP.
module vga_axis_counter #(
   parameter int unsigned TOTAL  = 800,
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter bit          POL    = 1'b0,
   parameter int unsigned CW     = $clog2(TOTAL)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          active,
   output logic          sync,
   output logic          wrap
);
   // One extra bit so a sync region ending exactly at TOTAL still compares.
   localparam logic [CW:0]   ACTIVE_END = (CW+1)'(ACTIVE);
   localparam logic [CW:0]   SYNC_BEG   = (CW+1)'(ACTIVE + FP);
   localparam logic [CW:0]   SYNC_END   = (CW+1)'(ACTIVE + FP + SYNC);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

   logic [CW:0] count_ext;

   assign count_ext = {1'b0, count};
   assign active    = (count_ext < ACTIVE_END);
   assign sync      = ((count_ext >= SYNC_BEG) && (count_ext < SYNC_END)) ? POL : ~POL;
   assign wrap      = (count == LAST);

   // Position counter, advanced only when enabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + CW'(1);
      end
   end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage.
// Request stage presents x,y one pixel ahead; output stage registers the
// colour with aligned HS/VS/BLANK. Optional macro: VGA_TEST_PATTERN_EN
// (adds test_mode, replacing rgb_in with 8 vertical colour bars).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int unsigned COLOR_BITS = COLOR_BITS_DEF
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   vga_timing_gen_if.master vga
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned XW      = $clog2(H_TOTAL);
   localparam int unsigned YW      = $clog2(V_TOTAL);
   localparam int unsigned DW      = $clog2(CLK_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   // Rounded-up half point: odd dividers get the longer phase low.
   localparam logic [DW-1:0] DIV_HIGH = DW'((CLK_DIV + 1) / 2);

   if (CLK_DIV < 2) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 2");
   end
   if (COLOR_BITS < 1 || COLOR_BITS > 8) begin : g_bits_check
      $error("vga_timing_gen: COLOR_BITS must be in 1..8");
   end

   typedef struct packed {
      logic [COLOR_BITS-1:0] r;
      logic [COLOR_BITS-1:0] g;
      logic [COLOR_BITS-1:0] b;
   } rgb_in_t;

   logic [DW-1:0] div;
   logic          pix_ce;
   logic          vga_clk;

   logic [XW-1:0] h_count;
   logic          h_active, h_sync, h_wrap;
   logic [YW-1:0] v_count;
   logic          v_active, v_sync;
   logic          v_wrap_unused;   // nothing downstream needs the frame wrap

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          req_valid_q;
   logic          line_start_q;
   logic          frame_start_q;
   logic          hs_req;
   logic          vs_req;

   logic          blank_n_q;
   logic          hs_q;
   logic          vs_q;
   rgb8_t         col_q;
   rgb8_t         col_next;
   rgb_in_t       pix;

   // Pixel-clock divider: counts 0..CLK_DIV-1, ticks on the last count.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         div <= '0;
      end else begin
         div <= pix_ce ? '0 : div + DW'(1);
      end
   end

   assign pix_ce  = (div == DIV_LAST);
   assign vga_clk = (div >= DIV_HIGH);

   vga_axis_counter #(
      .TOTAL  (H_TOTAL),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .POL    (HS_POL),
      .CW     (XW)
   ) u_h (
      .clk    (CLOCK_50),
      .reset  (reset),
      .en     (pix_ce),
      .count  (h_count),
      .active (h_active),
      .sync   (h_sync),
      .wrap   (h_wrap)
   );

   vga_axis_counter #(
      .TOTAL  (V_TOTAL),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .POL    (VS_POL),
      .CW     (YW)
   ) u_v (
      .clk    (CLOCK_50),
      .reset  (reset),
      .en     (pix_ce & h_wrap),
      .count  (v_count),
      .active (v_active),
      .sync   (v_sync),
      .wrap   (v_wrap_unused)
   );

   // Request stage: publish the current position and its decodes.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         x_q           <= '0;
         y_q           <= '0;
         req_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hs_req        <= ~HS_POL;
         vs_req        <= ~VS_POL;
      end else if (pix_ce) begin
         x_q           <= h_count;
         y_q           <= v_count;
         req_valid_q   <= h_active & v_active;
         line_start_q  <= (h_count == '0);
         frame_start_q <= (h_count == '0) && (v_count == '0);
         hs_req        <= h_sync;
         vs_req        <= v_sync;
      end
   end

   assign pix = vga.rgb_in;

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar;

   // Bar index across the visible width for the pixel being displayed.
   always_comb begin
      bar = 3'((32'(x_q) * 32'd8) / H_ACTIVE);
   end
`endif

   // Colour for the requested pixel, expanded to full DAC scale.
   always_comb begin
      col_next.r = expand_color(8'(pix.r), COLOR_BITS);
      col_next.g = expand_color(8'(pix.g), COLOR_BITS);
      col_next.b = expand_color(8'(pix.b), COLOR_BITS);
`ifdef VGA_TEST_PATTERN_EN
      if (vga.test_mode) begin
         col_next.r = {8{bar[2]}};
         col_next.g = {8{bar[1]}};
         col_next.b = {8{bar[0]}};
      end
`endif
   end

   // Output stage: one pixel after the request, syncs delayed to match.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         blank_n_q <= 1'b0;
         col_q     <= '0;
         hs_q      <= ~HS_POL;
         vs_q      <= ~VS_POL;
      end else if (pix_ce) begin
         blank_n_q <= req_valid_q;
         col_q     <= req_valid_q ? col_next : '0;
         hs_q      <= hs_req;
         vs_q      <= vs_req;
      end
   end

   assign vga.pix_ce      = pix_ce;
   assign vga.VGA_CLK     = vga_clk;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.req_valid   = req_valid_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.VGA_R       = col_q.r;
   assign vga.VGA_G       = col_q.g;
   assign vga.VGA_B       = col_q.b;
   assign vga.VGA_SYNC_N  = 1'b1;
   assign vga.VGA_BLANK_N = blank_n_q;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
endmodule
